wb_regfile: RTL and testbench

//  Write-back stage and architectural register file of the 16-bit pipeline. Consumes the
//  MEM/WB pipeline-register outputs, selects ALU result or RAM data, commits it on the CLK edge.

---
 rtl/cpu_defs_pkg.sv | 21 ++
 rtl/wb_src_mux.sv | 45 ++++
 rtl/wb_regfile.sv | 105 ++++++++++
 tb/tb_wb_regfile.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared pipeline definitions: register indices, WB source encodings and
// register-file sizing used by the write-back stage and its neighbours.
package cpu_defs_pkg;

    localparam int NREG = 12;

    localparam logic [3:0] idx_EMPTY = 4'hF;
    localparam logic [3:0] REG_SP    = 4'd8;
    localparam logic [3:0] REG_IH    = 4'd9;
    localparam logic [3:0] REG_RA    = 4'd10;
    localparam logic [3:0] REG_T     = 4'd11;

    localparam logic [7:0] WBSRC_ALU = 8'b0000_0001;
    localparam logic [7:0] WBSRC_RAM = 8'b0000_0010;
    localparam logic [7:0] EMPTY     = 8'b0000_1011;

    function automatic logic idx_valid(input logic [3:0] idx);
        return idx < 4'(NREG);
    endfunction

endpackage

// File: rtl/wb_src_mux.sv
// Write-back source decode: picks ALU or RAM data, qualifies the write and
// flags requests that the register file cannot honour.
module wb_src_mux
    import cpu_defs_pkg::*;
(
    input  logic [3:0]  wb_reg,
    input  logic [7:0]  wb_src,
    input  logic [15:0] alu_result,
    input  logic [15:0] ram_data,
    output logic [15:0] wb_data,
    output logic        wb_we,
    output logic        wb_illegal
);

    logic src_ok_s;
    logic src_bad_s;

    // Source decode, write qualification and illegal-request detection
    always_comb begin
        wb_data   = 16'h0000;
        src_ok_s  = 1'b0;
        src_bad_s = 1'b0;
        case (wb_src)
            WBSRC_ALU: begin
                wb_data  = alu_result;
                src_ok_s = 1'b1;
            end
            WBSRC_RAM: begin
                wb_data  = ram_data;
                src_ok_s = 1'b1;
            end
            EMPTY: begin
                src_ok_s = 1'b0;
            end
            default: begin
                src_bad_s = 1'b1;
            end
        endcase
        wb_we = src_ok_s && idx_valid(wb_reg);
        // idx_EMPTY is a bubble, never an error, whatever the source says
        wb_illegal = (wb_reg != idx_EMPTY) &&
                     ((src_ok_s && !idx_valid(wb_reg)) || src_bad_s);
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file: single write port,
// two write-through bypassed read ports, a registered debug port and status.
module wb_regfile
    import cpu_defs_pkg::*;
#(
    parameter logic [15:0] SP_INIT = 16'hBF00
) (
    input  logic        CLK,
    input  logic        RSTboot,
    input  logic [3:0]  WBReg_in,
    input  logic [7:0]  WBSrc_in,
    input  logic [15:0] ALU_result_in,
    input  logic [15:0] Ramdata_in,
    input  logic [3:0]  rd_idx_a,
    input  logic [3:0]  rd_idx_b,
    output logic [15:0] rd_data_a,
    output logic [15:0] rd_data_b,
    output logic        wb_we,
    output logic [3:0]  wb_idx,
    output logic [15:0] wb_data,
    input  logic [3:0]  dbg_idx,
    output logic [15:0] dbg_data,
    output logic [15:0] wb_count,
    output logic        wb_err
);

    logic [15:0] regs_q [NREG];
    logic [15:0] regs_d [NREG];
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [15:0] dbg_q;
    logic [15:0] dbg_d;
    logic        err_q;
    logic        err_d;
    logic        illegal_s;

    wb_src_mux u_src_mux (
        .wb_reg     (WBReg_in),
        .wb_src     (WBSrc_in),
        .alu_result (ALU_result_in),
        .ram_data   (Ramdata_in),
        .wb_data    (wb_data),
        .wb_we      (wb_we),
        .wb_illegal (illegal_s)
    );

    assign wb_idx   = WBReg_in;
    assign wb_count = count_q;
    assign wb_err   = err_q;
    assign dbg_data = dbg_q;

    // Next-state: commit, commit counter, sticky error and debug capture
    always_comb begin
        regs_d = regs_q;
        if (wb_we) begin
            regs_d[WBReg_in] = wb_data;
            count_d          = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
        err_d = err_q | illegal_s;
        // Debug sees pre-commit contents on purpose: no bypass here
        if (idx_valid(dbg_idx)) begin
            dbg_d = regs_q[dbg_idx];
        end else begin
            dbg_d = 16'h0000;
        end
    end

    // Read ports: write-through bypass so ID sees this cycle's commit
    always_comb begin
        if (wb_we && (rd_idx_a == WBReg_in)) begin
            rd_data_a = wb_data;
        end else if (idx_valid(rd_idx_a)) begin
            rd_data_a = regs_q[rd_idx_a];
        end else begin
            rd_data_a = 16'h0000;
        end
        if (wb_we && (rd_idx_b == WBReg_in)) begin
            rd_data_b = wb_data;
        end else if (idx_valid(rd_idx_b)) begin
            rd_data_b = regs_q[rd_idx_b];
        end else begin
            rd_data_b = 16'h0000;
        end
    end

    // State registers; reset discards any write presented on the same edge
    always_ff @(posedge CLK or negedge RSTboot) begin
        if (!RSTboot) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (4'(i) == REG_SP) ? SP_INIT : 16'h0000;
            end
            count_q <= 16'h0000;
            err_q   <= 1'b0;
            dbg_q   <= 16'h0000;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
            err_q   <= err_d;
            dbg_q   <= dbg_d;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a reference model pushes expected values to a
// scoreboard queue as each step is driven; DUT outputs are popped and compared.
module tb_wb_regfile;
    import cpu_defs_pkg::*;

    logic        CLK;
    logic        RSTboot;
    logic [3:0]  WBReg_in;
    logic [7:0]  WBSrc_in;
    logic [15:0] ALU_result_in;
    logic [15:0] Ramdata_in;
    logic [3:0]  rd_idx_a;
    logic [3:0]  rd_idx_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        wb_we;
    logic [3:0]  wb_idx;
    logic [15:0] wb_data;
    logic [3:0]  dbg_idx;
    logic [15:0] dbg_data;
    logic [15:0] wb_count;
    logic        wb_err;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    logic [15:0] mregs [12];
    logic [15:0] mcount;
    logic        merr;
    logic [15:0] mdbg;

    wb_regfile dut (
        .CLK           (CLK),
        .RSTboot       (RSTboot),
        .WBReg_in      (WBReg_in),
        .WBSrc_in      (WBSrc_in),
        .ALU_result_in (ALU_result_in),
        .Ramdata_in    (Ramdata_in),
        .rd_idx_a      (rd_idx_a),
        .rd_idx_b      (rd_idx_b),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .wb_we         (wb_we),
        .wb_idx        (wb_idx),
        .wb_data       (wb_data),
        .dbg_idx       (dbg_idx),
        .dbg_data      (dbg_data),
        .wb_count      (wb_count),
        .wb_err        (wb_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] m_data(input logic [7:0] src, input logic [15:0] alu,
                                           input logic [15:0] ram);
        if (src == 8'h01) return alu;
        if (src == 8'h02) return ram;
        return 16'h0000;
    endfunction

    function automatic logic m_we(input logic [3:0] idx, input logic [7:0] src);
        return (idx <= 4'd11) && (src == 8'h01 || src == 8'h02);
    endfunction

    function automatic logic m_ill(input logic [3:0] idx, input logic [7:0] src);
        if (idx == 4'hF) return 1'b0;
        if (src == 8'h01 || src == 8'h02) return idx >= 4'd12;
        return src != 8'h0B;
    endfunction

    function automatic logic [15:0] m_read(input logic [3:0] ix, input logic [3:0] widx,
                                           input logic we, input logic [15:0] wd);
        if (we && ix == widx) return wd;
        if (ix <= 4'd11) return mregs[ix];
        return 16'h0000;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 12; i++) mregs[i] = (i == 8) ? 16'hBF00 : 16'h0000;
        mcount = 16'h0000;
        merr   = 1'b0;
        mdbg   = 16'h0000;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // One WB cycle: drive at negedge, check combinational outputs, then state after posedge
    task automatic cycle(input logic [3:0] idx, input logic [7:0] src,
                         input logic [15:0] alu, input logic [15:0] ram,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] dg);
        logic [15:0] cd;
        logic        cw;
        logic        ci;
        @(negedge CLK);
        WBReg_in = idx; WBSrc_in = src; ALU_result_in = alu; Ramdata_in = ram;
        rd_idx_a = ra; rd_idx_b = rb; dbg_idx = dg;
        cd = m_data(src, alu, ram);
        cw = m_we(idx, src);
        ci = m_ill(idx, src);
        exp_q.push_back(cd);
        exp_q.push_back({15'd0, cw});
        exp_q.push_back({12'd0, idx});
        exp_q.push_back(m_read(ra, idx, cw, cd));
        exp_q.push_back(m_read(rb, idx, cw, cd));
        #2;
        chk("wb_data", wb_data);
        chk("wb_we", {15'd0, wb_we});
        chk("wb_idx", {12'd0, wb_idx});
        chk("rd_data_a", rd_data_a);
        chk("rd_data_b", rd_data_b);
        @(posedge CLK);
        mdbg = (dg <= 4'd11) ? mregs[dg] : 16'h0000;
        if (cw) begin
            mregs[idx] = cd;
            mcount     = mcount + 16'd1;
        end
        if (ci) merr = 1'b1;
        exp_q.push_back(mcount);
        exp_q.push_back({15'd0, merr});
        exp_q.push_back(mdbg);
        #1;
        chk("wb_count", wb_count);
        chk("wb_err", {15'd0, wb_err});
        chk("dbg_data", dbg_data);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #3 RSTboot = 1'b0;
        m_reset();
        #4 RSTboot = 1'b1;
    endtask

    initial begin
        RSTboot = 1'b1;
        WBReg_in = 4'hF; WBSrc_in = 8'h0B; ALU_result_in = 16'h0000; Ramdata_in = 16'h0000;
        rd_idx_a = 4'h0; rd_idx_b = 4'h0; dbg_idx = 4'h0;
        m_reset();
        do_reset();

        for (int i = 0; i < 16; i++)
            cycle(4'hF, 8'h0B, 16'h0000, 16'h0000, 4'(i), 4'(15 - i), 4'(i));

        cycle(4'd3, 8'h01, 16'h1234, 16'h0000, 4'd3, 4'd3, 4'd3);
        cycle(4'hF, 8'h0B, 16'h0000, 16'h0000, 4'd3, 4'd3, 4'd3);

        cycle(REG_RA, 8'h02, 16'h0001, 16'hBEEF, REG_RA, 4'd3, REG_RA);
        cycle(4'd1, 8'h01, 16'h1111, 16'h0000, 4'd1, 4'd2, 4'd1);
        cycle(4'd2, 8'h02, 16'h0000, 16'h2222, 4'd1, 4'd2, 4'd1);
        cycle(4'd1, 8'h01, 16'h3333, 16'h9999, 4'd1, 4'd2, 4'd1);
        cycle(4'hF, 8'h0B, 16'h0000, 16'h0000, 4'd1, 4'd2, REG_RA);

        cycle(4'hF, 8'h01, 16'hDEAD, 16'h0000, 4'hF, 4'd3, 4'd3);
        cycle(4'hF, 8'h55, 16'hDEAD, 16'hDEAD, 4'hF, 4'd1, 4'd1);
        cycle(4'd13, 8'h01, 16'hDEAD, 16'h0000, 4'd13, REG_SP, 4'd13);
        cycle(4'hF, 8'h0B, 16'h0000, 16'h0000, REG_IH, REG_T, REG_SP);
        cycle(4'd2, 8'h40, 16'hDEAD, 16'hDEAD, 4'd2, 4'd2, 4'd2);

        cycle(4'd5, 8'h01, 16'h5A5A, 16'h0000, 4'd5, 4'd5, 4'd5);
        cycle(4'hF, 8'h0B, 16'h0000, 16'h0000, 4'd5, 4'd5, 4'd5);

        do_reset();
        @(negedge CLK);
        WBReg_in = 4'd0; WBSrc_in = 8'h01; ALU_result_in = 16'h00AA; dbg_idx = 4'd0;
        repeat (65534) @(posedge CLK);
        mcount   = 16'hFFFE;
        mregs[0] = 16'h00AA;
        cycle(4'd0, 8'h01, 16'h00AB, 16'h0000, 4'd0, 4'd1, 4'd0);
        cycle(4'd0, 8'h01, 16'h00AC, 16'h0000, 4'd0, 4'd1, 4'd0);

        @(negedge CLK);
        WBReg_in = 4'd6; WBSrc_in = 8'h01; ALU_result_in = 16'h5555;
        #3 RSTboot = 1'b0;
        m_reset();
        #4;
        WBReg_in = 4'hF; WBSrc_in = 8'h0B;
        RSTboot = 1'b1;
        cycle(4'hF, 8'h0B, 16'h0000, 16'h0000, 4'd6, REG_SP, 4'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
